// File: rtl/result_tx_packer_pkg.sv
// ----------------------------------------------------------------------------
// result_tx_packer_pkg
// Shared definitions for the result transmit packer: FSM state encoding, the
// lost-ack timeout, the default result word size and a width helper.
// ----------------------------------------------------------------------------
package result_tx_packer_pkg;

    // Default number of bytes in one result word.
    localparam int unsigned DefaultNbytes = 3;

    // Cycles WAIT_ACK waits for tx_busy before assuming the ack was lost.
    localparam int unsigned AckTimeout = 16;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSettle   = 3'd1,
        StCapture  = 3'd2,
        StSend     = 3'd3,
        StWaitAck  = 3'd4,
        StWaitDone = 3'd5
    } tx_state_e;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// ----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous level strobe followed by a rising
// edge detector producing a one-cycle pulse in the clk domain.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   async_in  asynchronous level input
//   rise      one-cycle pulse on a synchronized 0->1 transition
// ----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    // Tracks how many real samples have entered the pipeline since reset
    // release. The reset value of sync_q/prev_q is not an observation of the
    // input, so an input already high at release must not look like an edge.
    logic [2:0] fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            fill_q <= 3'b000;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fill_q <= {fill_q[1:0], 1'b1};
        end
    end

    // fill_q[2] set: both sync_q and prev_q hold genuine input samples.
    assign rise = sync_q & ~prev_q & fill_q[2];

endmodule

// File: rtl/result_tx_packer.sv
// ----------------------------------------------------------------------------
// result_tx_packer
// On each rising edge of rx_irq, waits SETTLE_CYCLES for the filter to settle,
// captures the NBYTES-wide result word and sends it MSB first, one byte at a
// time, through a simple tx_en / tx_busy UART handshake. One extra event may be
// queued while busy; further events are dropped and flagged as overrun.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_irq       asynchronous receive-complete level (sample event source)
//   data_in      filter result word, 8*NBYTES bits
//   tx_busy      UART transmitter busy
//   overrun_clr  synchronous clear of overrun
//   tx_data      byte presented to the transmitter (holds outside SEND)
//   tx_en        single-cycle transmit request
//   busy         FSM not in IDLE
//   overrun      sticky lost-event flag
// ----------------------------------------------------------------------------
module result_tx_packer
    import result_tx_packer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NBYTES        = DefaultNbytes
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_irq,
    input  logic [8*NBYTES-1:0]   data_in,
    input  logic                  tx_busy,
    input  logic                  overrun_clr,
    output logic [7:0]            tx_data,
    output logic                  tx_en,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned CntW = cnt_width(SETTLE_CYCLES);
    localparam int unsigned IdxW = cnt_width(NBYTES);
    localparam int unsigned AckW = cnt_width(AckTimeout);

    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast    = IdxW'(NBYTES - 1);
    localparam logic [AckW-1:0] AckLast    = AckW'(AckTimeout - 1);

    tx_state_e              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [AckW-1:0]        ack_q, ack_d;
    logic [8*NBYTES-1:0]    hold_q, hold_d;
    logic [7:0]             txd_q, txd_d;
    logic                   pend_q, pend_d;
    logic                   ovr_q, ovr_d;

    logic                   sample_evt;
    logic                   fsm_busy;
    logic                   ovr_set;
    logic [8*NBYTES-1:0]    hold_shifted;
    logic [7:0]             cur_byte;

    sync_edge u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (rx_irq),
        .rise     (sample_evt)
    );

    // Index 0 selects the most significant byte of the held word.
    assign hold_shifted = hold_q << (8 * idx_q);
    assign cur_byte     = hold_shifted[8*NBYTES-1 -: 8];

    assign fsm_busy = (state_q != StIdle);

    // ------------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ack_d   = ack_q;
        hold_d  = hold_q;
        txd_d   = txd_q;

        case (state_q)
            StIdle: begin
                if (sample_evt || pend_q) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                hold_d  = data_in;
                idx_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                // Remember the byte so tx_data keeps it after SEND.
                txd_d   = cur_byte;
                ack_d   = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                // A missing busy pulse must not stall the word forever.
                if (tx_busy || (ack_q == AckLast)) begin
                    state_d = StWaitDone;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    if (idx_q == IdxLast) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StSend;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pending event and overrun bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        pend_d  = pend_q;
        ovr_set = 1'b0;

        if (sample_evt) begin
            if (fsm_busy) begin
                // Covers the cycle WAIT_DONE hands back to IDLE as well.
                if (pend_q) begin
                    ovr_set = 1'b1;
                end else begin
                    pend_d = 1'b1;
                end
            end else begin
                // IDLE starts on this event; an already queued one stays queued.
                pend_d = pend_q;
            end
        end else if (!fsm_busy) begin
            // IDLE consumes the queued event.
            pend_d = 1'b0;
        end

        ovr_d = ovr_q;
        if (overrun_clr) begin
            ovr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            ack_q   <= '0;
            hold_q  <= '0;
            txd_q   <= 8'h00;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            hold_q  <= hold_d;
            txd_q   <= txd_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign tx_en   = (state_q == StSend);
    assign tx_data = tx_en ? cur_byte : txd_q;
    assign busy    = fsm_busy;
    assign overrun = ovr_q;

endmodule
